// File: rtl/song_recorder.sv
// Song recorder: captures live key presses into 8-bit song-memory entries,
// timing notes and rests against a 1 ms tick and quantising them to length codes.
module song_recorder #(
    parameter int ADDR_BITS      = 6,
    parameter int DEPTH          = 64,
    parameter int TICKS_PER_UNIT = 125,
    parameter int MIN_TICKS      = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_tick,
    input  logic [6:0]           i_note_key,
    input  logic                 i_oct_up,
    input  logic                 i_oct_down,
    output logic                 o_wr_en,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [7:0]           o_wr_data,
    output logic [ADDR_BITS:0]   o_song_len,
    output logic                 o_recording,
    output logic                 o_full,
    output logic [6:0]           o_led,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_HOLD     = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Ticks are split into a sub-unit counter and a saturating unit count,
    // so the glitch threshold is checked on the sub-unit counter (MIN_TICKS < TICKS_PER_UNIT).
    localparam int SUB_W = $clog2(TICKS_PER_UNIT);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(TICKS_PER_UNIT - 1);
    localparam logic [SUB_W-1:0]   MIN_SUB  = SUB_W'(MIN_TICKS);
    localparam logic [ADDR_BITS:0] DEPTH_L  = (ADDR_BITS + 1)'(DEPTH);

    state_t               r_state;
    state_t               r_after;
    logic [SUB_W-1:0]     r_sub;
    logic [2:0]           r_units;
    logic [1:0]           r_octave;
    logic [6:0]           r_key;
    logic [2:0]           r_note;
    logic [1:0]           r_note_oct;
    logic [7:0]           r_wdata;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS:0]   r_len;
    logic                 r_full;

    state_t     w_next;
    state_t     w_after_nxt;
    logic       w_key_valid;
    logic [2:0] w_key_note;
    logic       w_hold_same;
    logic       w_long_enough;
    logic [2:0] w_note_len;
    logic       w_last;
    logic       w_clr_cnt;
    logic       w_cnt_en;
    logic       w_capture;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_begin;
    logic       w_commit;
    logic       w_abort;

    assign w_key_valid   = (i_note_key != 7'd0) && ((i_note_key & (i_note_key - 7'd1)) == 7'd0);
    assign w_hold_same   = w_key_valid && (i_note_key == r_key);
    assign w_long_enough = (r_units != 3'd0) || (r_sub >= MIN_SUB);
    assign w_note_len    = (r_units == 3'd0) ? 3'd1 : r_units;
    assign w_last        = ((r_len + 1'b1) == DEPTH_L);

    always_comb begin
        w_key_note = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (i_note_key[i]) w_key_note = 3'(i + 1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_after_nxt = r_after;
        w_clr_cnt   = 1'b0;
        w_cnt_en    = 1'b0;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_load_val  = r_wdata;
        w_begin     = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        if (!i_en) begin
            w_next  = S_IDLE;
            w_abort = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_next    = S_WAIT_KEY;
                        w_begin   = 1'b1;
                        w_clr_cnt = 1'b1;
                    end
                end
                S_WAIT_KEY: begin
                    if (i_stop) begin
                        w_next = S_DONE;
                    end else if (w_key_valid) begin
                        w_capture = 1'b1;
                        w_clr_cnt = 1'b1;
                        if (r_units != 3'd0) begin
                            w_next      = S_WRITE;
                            w_after_nxt = S_HOLD;
                            w_load      = 1'b1;
                            w_load_val  = {3'd0, 2'd0, r_units};
                        end else begin
                            w_next = S_HOLD;
                        end
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_stop || !w_hold_same) begin
                        w_clr_cnt = 1'b1;
                        if (w_long_enough) begin
                            w_next      = S_WRITE;
                            w_after_nxt = i_stop ? S_DONE : S_WAIT_KEY;
                            w_load      = 1'b1;
                            w_load_val  = {r_note, r_note_oct, w_note_len};
                        end else begin
                            w_next = i_stop ? S_DONE : S_WAIT_KEY;
                        end
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                S_WRITE: begin
                    w_commit = 1'b1;
                    // A full memory ends the take, dropping any note still pending.
                    if (w_last || i_stop) w_next = S_DONE;
                    else                  w_next = r_after;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_after    <= S_IDLE;
            r_sub      <= '0;
            r_units    <= 3'd0;
            r_octave   <= 2'd1;
            r_key      <= 7'd0;
            r_note     <= 3'd0;
            r_note_oct <= 2'd0;
            r_wdata    <= 8'd0;
            r_addr     <= '0;
            r_len      <= '0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_after <= w_after_nxt;

            if (i_oct_up && !i_oct_down && r_octave != 2'd2)      r_octave <= r_octave + 2'd1;
            else if (i_oct_down && !i_oct_up && r_octave != 2'd0) r_octave <= r_octave - 2'd1;

            if (w_clr_cnt) begin
                r_sub   <= '0;
                r_units <= 3'd0;
            end else if (w_cnt_en && i_tick) begin
                if (r_sub == SUB_LAST) begin
                    r_sub <= '0;
                    if (r_units != 3'd7) r_units <= r_units + 3'd1;
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end

            if (w_capture) begin
                r_key      <= i_note_key;
                r_note     <= w_key_note;
                r_note_oct <= r_octave;
            end

            if (w_load) r_wdata <= w_load_val;

            if (w_abort || w_begin) begin
                r_addr <= '0;
                r_len  <= '0;
                r_full <= 1'b0;
            end else if (w_commit) begin
                r_addr <= r_addr + 1'b1;
                r_len  <= r_len + 1'b1;
                if (w_last) r_full <= 1'b1;
            end
        end
    end

    assign o_wr_en     = (r_state == S_WRITE) && i_en;
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = (r_state == S_WRITE) ? r_wdata : 8'd0;
    assign o_song_len  = r_len;
    assign o_recording = (r_state == S_WAIT_KEY) || (r_state == S_HOLD) || (r_state == S_WRITE);
    assign o_full      = r_full;
    assign o_led       = (r_state == S_HOLD) ? r_key : 7'd0;
    assign o_dbg_state = r_state;

endmodule
